// File: rtl/hex_display_decoder.sv
// Receive-side decoder for a 4-digit active-low hex seven-segment display.
// It reports the 16-bit value once the whole 28-bit pattern has been stable for STABLE_CYCLES.
module hex_display_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [6:0]  digit0,
  input  logic [6:0]  digit1,
  input  logic [6:0]  digit2,
  input  logic [6:0]  digit3,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic [3:0]  data_err,
  output logic [7:0]  frame_count
);

  typedef enum logic [0:0] {StSettle, StHold} state_e;

  localparam logic [7:0] LastCnt = 8'(STABLE_CYCLES - 1);

  // Returns {illegal, nibble}; any pattern outside the table decodes as nibble 0.
  function automatic logic [4:0] decode_digit(input logic [6:0] seg_n);
    logic [6:0] seg;
    logic [4:0] res;
    seg = ~seg_n;
    res = 5'h10;
    case (seg)
      7'h3F: res = 5'h00;
      7'h06: res = 5'h01;
      7'h5B: res = 5'h02;
      7'h4F: res = 5'h03;
      7'h66: res = 5'h04;
      7'h6D: res = 5'h05;
      7'h7D: res = 5'h06;
      7'h07: res = 5'h07;
      7'h7F: res = 5'h08;
      7'h6F: res = 5'h09;
      7'h77: res = 5'h0A;
      7'h7C: res = 5'h0B;
      7'h39: res = 5'h0C;
      7'h5E: res = 5'h0D;
      7'h79: res = 5'h0E;
      7'h71: res = 5'h0F;
      default: res = 5'h10;
    endcase
    return res;
  endfunction

  logic [27:0] seg_in;
  logic [27:0] seg_q;
  logic [7:0]  stable_cnt_q, stable_cnt_d;
  state_e      state_q, state_d;
  logic        changed;
  logic        report;
  logic [15:0] dec_value;
  logic [3:0]  dec_err;

  assign seg_in  = {digit3, digit2, digit1, digit0};
  assign changed = (seg_in != seg_q);

  // Decode the live inputs; on a report edge they equal seg_q anyway.
  always_comb begin
    logic [4:0] d;
    dec_value = '0;
    dec_err   = '0;
    for (int i = 0; i < 4; i++) begin
      d = decode_digit(seg_in[7*i +: 7]);
      dec_value[4*i +: 4] = d[3:0];
      dec_err[i]          = d[4];
    end
  end

  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    report       = 1'b0;
    if (!en) begin
      state_d      = StSettle;
      stable_cnt_d = '0;
    end else begin
      unique case (state_q)
        StSettle: begin
          if (changed) begin
            stable_cnt_d = '0;
          end else if (stable_cnt_q == LastCnt) begin
            report       = 1'b1;
            stable_cnt_d = '0;
            state_d      = StHold;
          end else begin
            stable_cnt_d = stable_cnt_q + 8'd1;
          end
        end
        StHold: begin
          if (changed) begin
            state_d      = StSettle;
            stable_cnt_d = '0;
          end
        end
        default: begin
          state_d      = StSettle;
          stable_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q        <= '1;
      stable_cnt_q <= '0;
      state_q      <= StSettle;
      data_out     <= '0;
      data_valid   <= 1'b0;
      data_err     <= '0;
      frame_count  <= '0;
    end else begin
      seg_q        <= seg_in;
      stable_cnt_q <= stable_cnt_d;
      state_q      <= state_d;
      data_valid   <= report;
      if (report) begin
        data_out    <= dec_value;
        data_err    <= dec_err;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_decoder.sv
// Randomised and directed bench for hex_display_decoder against a run-length reference model.
module tb_hex_display_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset, en;
  logic [6:0]  digit0, digit1, digit2, digit3;
  logic [15:0] data_out;
  logic        data_valid;
  logic [3:0]  data_err;
  logic [7:0]  frame_count;

  hex_display_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .en(en),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .data_out(data_out), .data_valid(data_valid), .data_err(data_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Active-high segment patterns for hex 0..F.
  logic [6:0] hex_seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_cmp = 0;
  int n_bad = 0;
  int strobes = 0;
  logic [15:0] strobe_vals[$];

  // Reference model: length of the current unchanged run and whether it was already reported.
  logic [27:0] m_prev;
  int          m_run;
  bit          m_reported;
  logic [15:0] m_out;
  logic [3:0]  m_err;
  logic        m_valid;
  logic [7:0]  m_count;
  bit          m_live = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic decode_model(input logic [27:0] s, output logic [15:0] v, output logic [3:0] e);
    logic [6:0] seg;
    v = '0;
    e = '1;
    for (int d = 0; d < 4; d++) begin
      seg = ~s[7*d +: 7];
      for (int i = 0; i < 16; i++) begin
        if (seg == hex_seg[i]) begin
          v[4*d +: 4] = 4'(i);
          e[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic model_step();
    logic [27:0] cur;
    cur = {digit3, digit2, digit1, digit0};
    if (reset) begin
      m_prev = '1; m_run = 0; m_reported = 0;
      m_out = '0; m_err = '0; m_valid = 0; m_count = '0;
    end else begin
      m_valid = 1'b0;
      if (!en || cur != m_prev) begin
        m_run = 0;
        m_reported = 0;
      end else if (!m_reported) begin
        m_run++;
        if (m_run == S) begin
          decode_model(cur, m_out, m_err);
          m_valid = 1'b1;
          m_count = m_count + 8'd1;
          m_reported = 1;
          m_run = 0;
        end
      end
      m_prev = cur;
    end
    m_live = 1'b1;
  endtask

  // Compare process: every cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        cmp("data_valid", 32'(data_valid), 32'(m_valid));
        cmp("data_out", 32'(data_out), 32'(m_out));
        cmp("data_err", 32'(data_err), 32'(m_err));
        cmp("frame_count", 32'(frame_count), 32'(m_count));
        if (data_valid === 1'b1) begin
          strobes++;
          strobe_vals.push_back(data_out);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_all(input logic [6:0] d3, input logic [6:0] d2,
                         input logic [6:0] d1, input logic [6:0] d0);
    digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
  endtask

  // Ticks a fixed window and reports the tick index of the first strobe (-1 if none).
  task automatic wait_strobe(input int window, output int lat);
    lat = -1;
    for (int k = 1; k <= window; k++) begin
      tick(1);
      if (lat < 0 && data_valid === 1'b1) lat = k;
    end
  endtask

  int lat, s0;
  bit seen_bad;
  logic [6:0] p;

  initial begin
    reset = 1'b1; en = 1'b0;
    set_all(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    tick(2);
    cmp("reset data_out", 32'(data_out), 32'h0);
    cmp("reset data_valid", 32'(data_valid), 32'h0);
    cmp("reset data_err", 32'(data_err), 32'h0);
    cmp("reset frame_count", 32'(frame_count), 32'h0);
    reset = 1'b0; en = 1'b1;

    // Report path and latency.
    set_all(7'h79, 7'h08, 7'h12, 7'h0E);
    s0 = strobes;
    wait_strobe(20, lat);
    cmp("report latency", 32'(lat), 32'd5);
    cmp("report strobes", 32'(strobes - s0), 32'd1);
    cmp("report data_out", 32'(data_out), 32'h1A5F);
    cmp("report data_err", 32'(data_err), 32'h0);
    cmp("report frame_count", 32'(frame_count), 32'd1);

    // Full table from reset.
    reset = 1'b1; tick(1); reset = 1'b0;
    s0 = strobes;
    for (int n = 0; n < 16; n++) begin
      p = ~hex_seg[n];
      set_all(p, p, p, p);
      tick(10);
    end
    cmp("table strobes", 32'(strobes - s0), 32'd16);
    for (int n = 0; n < 16; n++)
      cmp("table value", 32'(strobe_vals[s0 + n]), 32'(16'h1111 * n));
    cmp("table frame_count", 32'(frame_count), 32'd16);

    // Illegal blank digit.
    set_all(7'h40, 7'h40, 7'h7F, 7'h40);
    tick(10);
    cmp("illegal data_out", 32'(data_out), 32'h0);
    cmp("illegal data_err", 32'(data_err), 32'h2);

    // Glitch rejection.
    set_all(7'h79, 7'h24, 7'h30, 7'h19);
    tick(10);
    cmp("glitch base", 32'(data_out), 32'h1234);
    s0 = strobes;
    digit1 = 7'h19;
    tick(2);
    digit1 = 7'h30;
    tick(10);
    cmp("glitch strobes", 32'(strobes - s0), 32'd1);
    seen_bad = 0;
    for (int i = s0; i < strobes; i++) if (strobe_vals[i] == 16'h1244) seen_bad = 1;
    cmp("glitch not reported", 32'(seen_bad), 32'd0);
    cmp("glitch resettle", 32'(strobe_vals[strobes - 1]), 32'h1234);

    // Enable low, then reset on the third settle cycle.
    en = 1'b0;
    set_all(7'h12, 7'h02, 7'h78, 7'h00);
    s0 = strobes;
    tick(20);
    cmp("en low strobes", 32'(strobes - s0), 32'd0);
    en = 1'b1;
    tick(2);
    reset = 1'b1; tick(1); reset = 1'b0;
    cmp("midreset data_out", 32'(data_out), 32'h0);
    cmp("midreset data_valid", 32'(data_valid), 32'h0);
    cmp("midreset data_err", 32'(data_err), 32'h0);
    cmp("midreset frame_count", 32'(frame_count), 32'h0);
    wait_strobe(20, lat);
    cmp("post reset latency", 32'(lat), 32'd5);
    cmp("post reset data_out", 32'(data_out), 32'h5678);

    // Counter wrap after 256 reports.
    reset = 1'b1; tick(1); reset = 1'b0;
    s0 = strobes;
    for (int i = 0; i < 256; i++) begin
      p = (i % 2 == 0) ? 7'h40 : 7'h0E;
      set_all(p, p, p, p);
      tick(7);
    end
    cmp("wrap strobes", 32'(strobes - s0), 32'd256);
    cmp("wrap frame_count", 32'(frame_count), 32'h0);

    // Randomised traffic against the model.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        for (int d = 0; d < 4; d++) begin
          p = ($urandom_range(0, 9) < 8) ? ~hex_seg[$urandom_range(0, 15)] : 7'($urandom);
          case (d)
            0: digit0 = p;
            1: digit1 = p;
            2: digit2 = p;
            default: digit3 = p;
          endcase
        end
      end
      en    = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 49) == 0);
      tick($urandom_range(1, 8));
      reset = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
